// File: rtl/imem_loader.sv
// imem_loader
//   Loads a program image, received as a byte stream, into instruction memory.
//   The byte order is big-endian, the same as the fetch path: byte address
//   4n+0 holds instruction bits [31:24] and 4n+3 holds bits [7:0].
//
//   Stream format: word_count[15:8], word_count[7:0], word_count*4 payload
//   bytes, then one checksum byte. The checksum byte is the XOR of the
//   payload bytes only.
//
//   While a load is in progress, cpu_hold stalls the PC/fetch path.
//
// Ports
//   CLK        clock; all logic runs on posedge
//   RESET      synchronous, active-high reset
//   start      pulse; begins a load from IDLE, DONE or ERR
//   in_data    stream byte
//   in_valid   in_data is valid
//   in_ready   the loader accepts a byte this cycle
//   mem_we     byte write strobe to instruction memory (registered)
//   mem_addr   byte write address (registered, holds between writes)
//   mem_wdata  byte write data (registered)
//   cpu_hold   stall for the PC/fetch path while a load is in progress
//   load_done  level; the last load completed with a good checksum
//   load_err   level; the last load failed on size or checksum
module imem_loader #(
  parameter int ADDR_W    = 10,
  parameter int MEM_BYTES = 1024,
  parameter int BASE_ADDR = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam int                MAX_WORDS = MEM_BYTES / 4;
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    IDLE, HDR_HI, HDR_LO, PAYLOAD, CHECK, DONE, ERR
  } state_t;

  state_t          state;
  logic [15:0]     word_count;
  logic [ADDR_W:0] byte_cnt;
  logic [7:0]      checksum;

  logic            xfer;
  logic [15:0]     hdr_count;
  logic [ADDR_W:0] byte_cnt_nx;
  logic            last_byte;

  // in_ready is a function of state only.
  assign in_ready    = (state == HDR_HI) || (state == HDR_LO) ||
                       (state == PAYLOAD) || (state == CHECK);
  assign xfer        = in_valid && in_ready;

  // The full word count becomes known in HDR_LO, when the low byte arrives.
  assign hdr_count   = {word_count[15:8], in_data};

  // byte_cnt is one bit wider than the address, so a load of exactly
  // MEM_BYTES/4 words reaches its end count without wrapping.
  assign byte_cnt_nx = byte_cnt + 1'b1;
  assign last_byte   = (18'(byte_cnt_nx) == {word_count, 2'b00});

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      mem_we     <= 1'b0;
      mem_addr   <= BASE;
      mem_wdata  <= 8'h00;
      cpu_hold   <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      checksum   <= 8'h00;
      word_count <= 16'h0000;
      byte_cnt   <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state      <= HDR_HI;
            checksum   <= 8'h00;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            byte_cnt   <= '0;
            word_count <= 16'h0000;
            cpu_hold   <= 1'b1;
          end
        end
        HDR_HI: begin
          if (xfer) begin
            word_count[15:8] <= in_data;
            state            <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (xfer) begin
            word_count[7:0] <= in_data;
            if (hdr_count > 16'(MAX_WORDS)) begin
              state    <= ERR;
              load_err <= 1'b1;
              cpu_hold <= 1'b0;
            end else if (hdr_count == 16'h0000) begin
              state <= CHECK;
            end else begin
              state <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          // The write is registered: the strobe appears one cycle after the
          // transfer, for exactly one cycle.
          if (xfer) begin
            mem_we    <= 1'b1;
            mem_addr  <= BASE + byte_cnt[ADDR_W-1:0];
            mem_wdata <= in_data;
            checksum  <= checksum ^ in_data;
            byte_cnt  <= byte_cnt_nx;
            if (last_byte) state <= CHECK;
          end
        end
        CHECK: begin
          // The final write strobe has already been issued, so releasing
          // cpu_hold on this edge is safe.
          if (xfer) begin
            cpu_hold <= 1'b0;
            if (in_data == checksum) begin
              state     <= DONE;
              load_done <= 1'b1;
            end else begin
              state    <= ERR;
              load_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader. The stimulus process drives directed byte
// streams and pushes each expected memory write into a queue. A separate
// monitor pops an entry from that queue on every mem_we pulse and compares
// it with the write the DUT presents.
module tb_imem_loader;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       mem_we;
  logic [9:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_hold;
  logic       load_done;
  logic       load_err;

  int n_vec = 0;
  int n_err = 0;

  // Each entry is one expected write, packed as {addr, data}.
  logic [17:0] exp_q[$];

  imem_loader #(.ADDR_W(10), .MEM_BYTES(1024), .BASE_ADDR(0)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every write strobe against the scoreboard queue.
  always @(negedge CLK) begin
    if (mem_we === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write",
                 mem_addr, mem_wdata);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          n_err++;
          $display("FAIL write: got addr=%0h data=%0h expected addr=%0h data=%0h",
                   mem_addr, mem_wdata, e[17:8], e[7:0]);
        end
      end
    end
  end

  // Send one byte after `gap` idle cycles. Idle cycles carry garbage data.
  task automatic send(input logic [7:0] b, input int gap);
    bit ok;
    for (int i = 0; i < gap; i++) begin
      @(negedge CLK);
      in_valid = 1'b0;
      in_data  = 8'hA5;
    end
    @(negedge CLK);
    in_data  = b;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL send_timeout: got in_ready=0 for byte %0h expected 1", b);
    end else begin
      @(posedge CLK);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    chk("cpu_hold_rise", cpu_hold, 1);
  endtask

  task automatic push_good(input logic [9:0] base);
    exp_q.push_back({base + 10'd0, 8'h08});
    exp_q.push_back({base + 10'd1, 8'h01});
    exp_q.push_back({base + 10'd2, 8'h10});
    exp_q.push_back({base + 10'd3, 8'h00});
  endtask

  // Stream 00 01 08 01 10 00 <ck>. The expected writes must already be queued.
  task automatic good_stream(input logic [7:0] ck, input int gap);
    logic [7:0] pl [4];
    pl[0] = 8'h08; pl[1] = 8'h01; pl[2] = 8'h10; pl[3] = 8'h00;
    send(8'h00, gap);
    send(8'h01, gap);
    for (int i = 0; i < 4; i++) send(pl[i], gap);
    chk("last_write_hold", {31'd0, cpu_hold}, 1);
    chk("last_write_we", {31'd0, mem_we}, 1);
    send(ck, gap);
  endtask

  task automatic chk_end(input string tag, input logic d, input logic e);
    chk({tag, "_done"}, load_done, d);
    chk({tag, "_err"}, load_err, e);
    chk({tag, "_hold"}, cpu_hold, 0);
    chk({tag, "_ready"}, in_ready, 0);
    chk({tag, "_pending"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1; start = 1'b0; in_data = 8'h00; in_valid = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_ready", in_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_hold", cpu_hold, 0);
    chk("rst_done", load_done, 0);
    chk("rst_err", load_err, 0);
    RESET = 1'b0;

    // Good load: the checksum is 08^01^10^00 = 19.
    pulse_start();
    push_good(10'd0);
    good_stream(8'h19, 0);
    chk_end("good", 1, 0);
    chk("good_addr_hold", mem_addr, 3);

    // Bad checksum: the writes still happen, then the load errors.
    pulse_start();
    chk("restart_done_clr", load_done, 0);
    push_good(10'd0);
    good_stream(8'h18, 0);
    chk_end("badck", 0, 1);

    // Oversize: 257 words is more than 256, so the load errors on the header.
    pulse_start();
    send(8'h01, 0);
    send(8'h01, 0);
    chk_end("oversize", 0, 1);
    @(negedge CLK);
    in_valid = 1'b1;
    in_data  = 8'h33;
    repeat (3) @(negedge CLK);
    chk("oversize_ready_stays", in_ready, 0);
    in_valid = 1'b0;

    // Gaps between every byte give identical results.
    pulse_start();
    push_good(10'd0);
    good_stream(8'h19, 1);
    chk_end("gaps", 1, 0);

    // Empty loads.
    pulse_start();
    send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    chk_end("empty_ok", 1, 0);
    pulse_start();
    send(8'h00, 0); send(8'h00, 0); send(8'h5A, 0);
    chk_end("empty_bad", 0, 1);

    // Reset mid-load, after two payload bytes.
    pulse_start();
    exp_q.push_back({10'd0, 8'h08});
    exp_q.push_back({10'd1, 8'h01});
    send(8'h00, 0); send(8'h01, 0); send(8'h08, 0); send(8'h01, 0);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk("midrst_hold", cpu_hold, 0);
    chk("midrst_we", mem_we, 0);
    chk("midrst_ready", in_ready, 0);
    chk("midrst_addr", mem_addr, 0);
    chk("midrst_err", load_err, 0);
    chk("midrst_pending", exp_q.size(), 0);

    // A good load after the reset starts again from address 0.
    pulse_start();
    push_good(10'd0);
    good_stream(8'h19, 0);
    chk_end("after_rst", 1, 0);

    repeat (3) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart to the instruction memory fetch path: receives a program image as a byte stream and writes it into instruction memory.
- Layout is big-endian, identical to fetch: address 4n+0 holds INSTRUCTION[31:24], 4n+3 holds [7:0].
- Holds the PC/fetch path via cpu_hold while loading.
- Verifies a trailing XOR checksum and reports done/error.

Parameters:
- ADDR_W, 10, byte-address width of instruction memory.
- MEM_BYTES, 1024, memory size in bytes; max loadable words = MEM_BYTES/4.
- BASE_ADDR, 0, byte address of the first written byte; must be a multiple of 4.

Ports:
- CLK  in  1  clock; all logic on posedge.
- RESET  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a load when in IDLE, DONE or ERR.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  byte write strobe to instruction memory.
- mem_addr  out  ADDR_W  byte write address.
- mem_wdata  out  8  byte write data.
- cpu_hold  out  1  stall PC/fetch while high.
- load_done  out  1  level; last load completed with a good checksum.
- load_err  out  1  level; last load failed (size or checksum).

Behaviour:
- Reset, and the value after RESET: state=IDLE, in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=0, load_done=0, load_err=0, checksum=0, counters=0. RESET has priority over every other input.
- Transfer: occurs on a posedge where in_valid && in_ready. in_ready is a pure function of state:
  - 1 in HDR_HI, HDR_LO, PAYLOAD, CHECK.
  - 0 in IDLE, DONE, ERR.
- States:
  - IDLE: start -> HDR_HI. On entry, clear checksum, load_done, load_err and the byte counter; set cpu_hold=1.
  - HDR_HI: transfer latches word_count[15:8] -> HDR_LO.
  - HDR_LO: transfer latches word_count[7:0], then:
    - full count > MEM_BYTES/4 -> ERR.
    - count == 0 -> CHECK.
    - otherwise -> PAYLOAD.
  - PAYLOAD: each transfer writes one byte and XORs it into checksum. After the byte that completes word_count*4 bytes -> CHECK.
  - CHECK: on transfer, byte == checksum -> DONE, else -> ERR.
  - DONE: load_done=1, cpu_hold=0; start -> HDR_HI.
  - ERR: load_err=1, cpu_hold=0; start -> HDR_HI.
- Write timing:
  - mem_we/mem_addr/mem_wdata are registered: asserted the cycle after the payload transfer, for exactly one cycle per byte.
  - Address of the k-th payload byte (k from 0) = BASE_ADDR + k.
  - mem_addr holds its last value when mem_we=0.
- Idle gaps: in_valid low in any accepting state leaves state, counters and checksum unchanged.
- cpu_hold: rises the cycle after start is accepted. Falls on the same edge that enters DONE/ERR, which is after the final mem_we pulse has been issued.
- Ignored inputs: start while in HDR_HI..CHECK is ignored. in_data outside a transfer is ignored.
- Checksum scope: XOR over payload bytes only; header bytes are excluded.
- RESET mid-load: returns to IDLE with all outputs at reset values. Bytes already written stay in memory; nothing is rolled back.
- Width rules: word_count is 16 bits. The byte counter is ADDR_W+1 bits, so a count of exactly MEM_BYTES/4 completes without wrap.

Test Plan:
- Good load: start; stream 00 01 08 01 10 00 19 -> mem_we pulses write addr0=08, addr1=01, addr2=10, addr3=00; load_done=1, load_err=0, cpu_hold low after the 4th write.
- Bad checksum: same stream with final byte 18 -> 4 writes occur; load_err=1, load_done=0, cpu_hold=0.
- Oversize: start; stream 01 01 (257 > 256) -> ERR on the HDR_LO transfer; zero mem_we pulses; in_ready=0 thereafter.
- Backpressure/gaps: good-load stream with in_valid toggling every other cycle -> identical writes and final state; exactly 4 mem_we pulses.
- Empty load: stream 00 00 00 -> DONE, no writes; stream 00 00 5A -> ERR.
- Reset mid-load: RESET after 2 payload bytes -> next cycle IDLE, cpu_hold=0, mem_we=0; a following good load completes normally from addr0.
